// File: rtl/share_reporter.sv
// share_reporter: absorbs held hasher shares, queues each distinct one and streams it as a byte frame.
// Optional macro SHARE_RESULT_EN carries the 256-bit result in each entry and frame.
module share_reporter #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_in,
    input  logic [31:0]       time_in,
    input  logic [31:0]       nonce_in,
    input  logic [255:0]      result_in,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    input  logic              clear_overflow
);

`ifdef SHARE_RESULT_EN
    localparam int unsigned ENTRY_W = 320;
`else
    localparam int unsigned ENTRY_W = 64;
`endif
    localparam int unsigned PAY_BYTES = ENTRY_W / 8;
    localparam int unsigned FRAME_LEN = PAY_BYTES + 2;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam logic [7:0]       HEADER   = 8'hA5;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    logic [ENTRY_W-1:0] entry_in;
`ifdef SHARE_RESULT_EN
    assign entry_in = {time_in, nonce_in, result_in};
`else
    logic unused_result;
    assign entry_in      = {time_in, nonce_in};
    assign unused_result = ^result_in;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ENTRY_W-1:0] frame_q, frame_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               seen_q, seen_d;
    logic [31:0]        last_nonce_q, last_nonce_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic               push_req, push_ok, pop, full;
    logic [IDX_W-1:0]   nxt_idx;
    logic [7:0]         nxt_byte, csum;

    // Byte that follows the current one; payload bytes go out MSB first, checksum closes the frame.
    always_comb begin
        nxt_idx  = idx_q + 1'b1;
        nxt_byte = 8'h00;
        csum     = HEADER;
        for (int b = 0; b < int'(PAY_BYTES); b++) begin
            csum = csum ^ frame_q[ENTRY_W-8*(b+1) +: 8];
            if (nxt_idx == IDX_W'(b + 1)) begin
                nxt_byte = frame_q[ENTRY_W-8*(b+1) +: 8];
            end
        end
        if (nxt_idx == LAST_IDX) begin
            nxt_byte = csum;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        seen_d       = seen_q;
        last_nonce_d = last_nonce_q;

        // A held share repeats its nonce, so only a new nonce (or the first share) is a push.
        push_req = valid_in && (!seen_q || (nonce_in != last_nonce_q));
        full     = (count_q == FULL_CNT);
        pop      = (state_q == IDLE) && (count_q != '0);
        push_ok  = push_req && (!full || pop);

        if (push_req) begin
            seen_d       = 1'b1;
            last_nonce_d = nonce_in;
        end
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push_ok) count_d = count_q - 1'b1;

        if (push_req && !push_ok) overflow_d = 1'b1;
        else if (clear_overflow)  overflow_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    frame_d    = mem_q[rd_ptr_q];
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = HEADER;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        state_d    = IDLE;
                    end else begin
                        idx_d     = nxt_idx;
                        tx_data_d = nxt_byte;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            frame_q      <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            seen_q       <= 1'b0;
            last_nonce_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            seen_q       <= seen_d;
            last_nonce_q <= last_nonce_d;
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_in;
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_share_reporter.sv
// Bench for share_reporter: frame-level scoreboard plus directed literal checks.
module tb_share_reporter;
    localparam int DEPTH = 4;
`ifdef SHARE_RESULT_EN
    localparam int FL = 42;
`else
    localparam int FL = 10;
`endif
    localparam logic [31:0]  T1 = 32'h130dae51;
    localparam logic [31:0]  N1 = 32'h3aeb9bb8;
    localparam logic [255:0] R1 = 256'h5C8AD782_9F31B6E0_4D7C2A18_E5F09B43_61D8A2C7_3B9E4F05_27010000_00000000;

    logic         CLK = 1'b0, RST = 1'b0;
    logic         valid_in = 1'b0, tx_ready = 1'b0, clear_overflow = 1'b0;
    logic [31:0]  time_in = '0, nonce_in = '0;
    logic [255:0] result_in = '0;
    logic [7:0]   tx_data;
    logic         tx_valid, overflow;
    logic [2:0]   fifo_count;

    share_reporter #(.DEPTH(4), .ADDR_W(2)) dut (
        .CLK(CLK), .RST(RST), .valid_in(valid_in), .time_in(time_in), .nonce_in(nonce_in),
        .result_in(result_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    int          base = 0;
    logic        exp_drop = 1'b0;
    logic        seen = 1'b0, model_ovf = 1'b0, stall = 1'b0;
    logic [31:0] last_nonce = '0;
    logic [7:0]  stall_data = '0;
    logic [7:0]  lit1 [10] = '{8'hA5, 8'h13, 8'h0D, 8'hAE, 8'h51, 8'h3A, 8'hEB, 8'h9B, 8'hB8, 8'hB6};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: header, time and nonce MSB first, optional result, XOR of all preceding bytes.
    task automatic add_frame(input logic [31:0] t, input logic [31:0] n, input logic [255:0] r);
        logic [7:0] b[$];
        logic [7:0] x;
        b.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) b.push_back(t[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(n[8*i +: 8]);
`ifdef SHARE_RESULT_EN
        for (int i = 31; i >= 0; i--) b.push_back(r[8*i +: 8]);
`else
        if (r == '1) b.push_back(8'h00);
`endif
        x = 8'h00;
        foreach (b[i]) x = x ^ b[i];
        b.push_back(x);
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    // Model: capture on rising edges, compare outputs on falling edges.
    always @(CLK) begin
        if (CLK) begin
            if (!RST) begin
                seen = 1'b0;
                model_ovf = 1'b0;
            end else if (valid_in && (!seen || nonce_in != last_nonce)) begin
                seen = 1'b1;
                last_nonce = nonce_in;
                if (exp_drop) model_ovf = 1'b1;
                else begin
                    add_frame(time_in, nonce_in, result_in);
                    if (clear_overflow) model_ovf = 1'b0;
                end
            end else if (clear_overflow) begin
                model_ovf = 1'b0;
            end
        end else begin
            if (!RST) begin
                check("rst_tx_valid", tx_valid, 0);
                check("rst_tx_data", tx_data, 0);
                check("rst_count", fifo_count, 0);
                check("rst_overflow", overflow, 0);
                exp_q.delete();
                model_ovf = 1'b0;
                stall = 1'b0;
            end else begin
                check("overflow", overflow, model_ovf);
                check("count_bound", 64'(fifo_count <= 3'(DEPTH)), 1);
                if (stall) begin
                    check("stall_valid", tx_valid, 1);
                    check("stall_data", tx_data, stall_data);
                end
                if (tx_valid && tx_ready) begin
                    log_q.push_back(tx_data);
                    if (exp_q.size() == 0) check("extra_byte", 0, 1);
                    else check("tx_byte", tx_data, exp_q.pop_front());
                end
                stall = tx_valid && !tx_ready;
                stall_data = tx_data;
            end
        end
    end

    function automatic logic [63:0] lb(input int i);
        if (base + i < log_q.size()) return 64'(log_q[base + i]);
        return 64'hDEAD;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        step();
        RST = 1'b0; valid_in = 1'b0; clear_overflow = 1'b0; exp_drop = 1'b0;
        #1;
        check("rst_async_valid", tx_valid, 0);
        check("rst_async_count", fifo_count, 0);
        repeat (3) step();
        RST = 1'b1;
        base = log_q.size();
    endtask

    task automatic present(input logic [31:0] t, input logic [31:0] n, input int cycles);
        step();
        time_in = t; nonce_in = n; valid_in = 1'b1;
        repeat (cycles) step();
        valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge CLK); #2;
            if (exp_q.size() == 0 && !tx_valid && fifo_count == 0) done = 1'b1;
        end
        check(name, 64'(done), 1);
        repeat (5) @(negedge CLK);
    endtask

    task automatic fill_five(input logic [31:0] first);
        step();
        valid_in = 1'b1;
        for (int n = 0; n < 5; n++) begin
            time_in = 32'h1000_0000 + first + 32'(n);
            nonce_in = first + 32'(n);
            step();
        end
        valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        result_in = R1;
        // Single share held for six cycles, literal frame and header timing.
        do_reset();
        tx_ready = 1'b1;
        step();
        time_in = T1; nonce_in = N1; valid_in = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("e0_count", fifo_count, 1);
        check("e0_valid", tx_valid, 0);
        @(posedge CLK);
        @(negedge CLK);
        check("e1_count", fifo_count, 0);
        check("e1_valid", tx_valid, 1);
        check("e1_header", tx_data, 8'hA5);
        repeat (4) @(posedge CLK);
        #1 valid_in = 1'b0;
        drain("drain_single");
        check("single_len", log_q.size() - base, FL);
        for (int i = 0; i < 9; i++) check("single_lit", lb(i), lit1[i]);
`ifndef SHARE_RESULT_EN
        check("single_csum", lb(9), 8'hB6);
`endif

        // Same share with the result attached.
        do_reset();
        present(T1, N1, 6);
        drain("drain_hash");
        check("hash_len", log_q.size() - base, FL);
`ifdef SHARE_RESULT_EN
        check("hash_b9", lb(9), 8'h5C);
        check("hash_b10", lb(10), 8'h8A);
        check("hash_b11", lb(11), 8'hD7);
        check("hash_b33", lb(33), 8'h27);
        check("hash_b34", lb(34), 8'h01);
        check("hash_b40", lb(40), 8'h00);
`else
        check("hash_b8", lb(8), 8'hB8);
        check("hash_csum", lb(9), 8'hB6);
`endif

        // Backpressure: toggling ready plus a five-cycle stall.
        do_reset();
        tx_ready = 1'b0;
        fork
            present(T1, N1, 6);
            for (int k = 0; k < 40; k++) begin
                step();
                tx_ready = (k >= 14 && k < 19) ? 1'b0 : 1'(k % 2);
            end
        join
        step();
        tx_ready = 1'b1;
        drain("drain_bp");
        check("bp_len", log_q.size() - base, FL);
        for (int i = 0; i < 9; i++) check("bp_lit", lb(i), lit1[i]);

        // Overflow: one share in the frame register, four queued, sixth dropped.
        do_reset();
        tx_ready = 1'b0;
        fill_five(32'd1);
        @(negedge CLK);
        check("ovf_count4", fifo_count, 4);
        check("ovf_still0", overflow, 0);
        check("ovf_head", tx_data, 8'hA5);
        step();
        time_in = 32'h1000_0006; nonce_in = 32'd6; valid_in = 1'b1; exp_drop = 1'b1;
        step();
        valid_in = 1'b0; exp_drop = 1'b0;
        @(negedge CLK);
        check("ovf_set", overflow, 1);
        check("ovf_count_held", fifo_count, 4);
        step();
        tx_ready = 1'b1;
        drain("drain_ovf");
        check("ovf_len", log_q.size() - base, 5 * FL);
        for (int k = 0; k < 5; k++) check("ovf_order", lb(k * FL + 8), k + 1);
        check("ovf_sticky", overflow, 1);
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        @(negedge CLK);
        check("ovf_cleared", overflow, 0);

        // Push on the same edge as the IDLE pop while full.
        do_reset();
        tx_ready = 1'b0;
        fill_five(32'd11);
        @(negedge CLK);
        check("full_count", fifo_count, 4);
        step();
        tx_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK); #2;
            if (!tx_valid && fifo_count == 3'd4) found = 1'b1;
        end
        check("full_idle_seen", 64'(found), 1);
        time_in = 32'h1000_0010; nonce_in = 32'd16; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        @(negedge CLK);
        check("pp_count", fifo_count, 4);
        check("pp_overflow", overflow, 0);
        check("pp_header", tx_data, 8'hA5);
        drain("drain_pp");
        check("pp_len", log_q.size() - base, 6 * FL);
        check("pp_last_nonce", lb(5 * FL + 8), 16);

        // Reset mid-frame with two entries queued, then the same nonce again.
        do_reset();
        tx_ready = 1'b1;
        step();
        valid_in = 1'b1;
        for (int n = 21; n < 24; n++) begin
            time_in = 32'h2000_0000 + 32'(n); nonce_in = 32'(n);
            step();
        end
        valid_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge CLK); #2;
            if (log_q.size() - base >= 4) found = 1'b1;
        end
        check("mid_reached", 64'(found), 1);
        check("mid_queued", fifo_count, 2);
        RST = 1'b0;
        #1;
        check("mid_rst_valid", tx_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        repeat (2) step();
        RST = 1'b1;
        repeat (20) step();
        check("mid_no_resume", log_q.size() - base, 4);
        base = log_q.size();
        step();
        time_in = 32'h2000_0015; nonce_in = 32'd21; valid_in = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("recapture_count", fifo_count, 1);
        @(posedge CLK);
        #1 valid_in = 1'b0;
        drain("drain_recap");
        check("recap_len", log_q.size() - base, FL);
        check("recap_nonce", lb(8), 8'h15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
